capture_buffer: RTL

- Parametrised trigger-aware sample buffer for the internal logic analyzer.
- Writes qualified samples circularly into a DEPTH-entry RAM while armed.
- On trigger, captures a programmable number of post-trigger samples, then freezes.
- Exposes trigger position, oldest-sample pointer and a registered read port for the readout/UART path.

---
 rtl/capture_buffer_pkg.sv | 16 +
 rtl/capture_ram.sv | 31 +++
 rtl/capture_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/capture_buffer_pkg.sv
// Shared definitions for the logic-analyzer capture buffer: FSM encoding and
// the RAM depth derived from the address width.
package capture_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one synchronous write port, one registered
// read port. A same-address read and write returns the old word.
module capture_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_buffer.sv
// Trigger-aware circular sample buffer: records qualified samples while armed,
// keeps post_count samples after the trigger, then freezes for readout.
module capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sample_en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  running,
  output logic                  triggered,
  output logic                  done,
  output logic                  primed,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] start_addr
);

  localparam int unsigned           DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0]   trig_q;
  logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
  logic                    primed_q;
  logic                    wr_en;

  // abort outranks the write; arm is only honoured in IDLE/DONE where no
  // write can happen, so it needs no gating here.
  assign wr_en   = !reset && !abort && sample_en && (state_q == RUN || state_q == POST);
  assign waddr_d = waddr_q + 1'b1;
  assign rem_d   = rem_q - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      trig_q   <= '0;
      rem_q    <= '0;
      primed_q <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
    end else if (arm && (state_q == IDLE || state_q == DONE)) begin
      state_q  <= RUN;
      waddr_q  <= '0;
      trig_q   <= '0;
      primed_q <= 1'b0;
    end else if (wr_en) begin
      waddr_q <= waddr_d;
      if (waddr_q == LAST) primed_q <= 1'b1;
      if (state_q == RUN) begin
        if (trigger) begin
          trig_q  <= waddr_q;
          rem_q   <= post_count;
          state_q <= (post_count == '0) ? DONE : POST;
        end
      end else begin
        rem_q <= rem_d;
        if (rem_q == 1) state_q <= DONE;
      end
    end
  end

  capture_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en),
    .waddr_i (waddr_q),
    .wdata_i (data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign running    = (state_q == RUN) || (state_q == POST);
  assign triggered  = (state_q == POST) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign primed     = primed_q;
  assign waddr      = waddr_q;
  assign trig_addr  = trig_q;
  assign start_addr = primed_q ? waddr_q : '0;

endmodule
